// File: rtl/rsa_pkg.sv
// Shared widths and FSM encoding for the modular add/subtract controller.
package rsa_pkg;

    localparam int OPW  = 1024;
    localparam int ADDW = 1027;
    localparam int RESW = 1028;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OP1   = 3'd1,
        WAIT1 = 3'd2,
        OP2   = 3'd3,
        WAIT2 = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mod_addsub_ctrl_if.sv
// Request/response bundle of the modular add/subtract controller.
interface mod_addsub_ctrl_if import rsa_pkg::*; #(
    parameter int OPW = rsa_pkg::OPW
);
    // start is a one-cycle request taken only while busy=0 (operands and subtract
    // sampled with it); done is a one-cycle pulse with result valid, result then
    // holds until the next done. start seen while busy=1 is dropped.
    logic           start;
    logic           subtract;
    logic [OPW-1:0] in_a;
    logic [OPW-1:0] in_b;
    logic [OPW-1:0] in_m;
    logic [OPW-1:0] result;
    logic           done;
    logic           busy;
    state_t         dbg_state;

    modport master (
        output start, subtract, in_a, in_b, in_m,
        input  result, done, busy, dbg_state
    );

    modport slave (
        input  start, subtract, in_a, in_b, in_m,
        output result, done, busy, dbg_state
    );
endinterface

// File: rtl/mpadder.sv
// Two-stage wide adder/subtractor: low half on the start edge, high half one edge later.
module mpadder import rsa_pkg::*; (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            subtract,
    input  logic [ADDW-1:0] in_a,
    input  logic [ADDW-1:0] in_b,
    output logic [RESW-1:0] result,
    output logic            done
);
    localparam int LOW = RESW / 2;
    localparam int HIW = RESW - LOW;

    logic [RESW-1:0] ext_a, ext_b;
    logic [LOW:0]    lo_d, lo_q;
    logic [HIW-1:0]  hi_a_d, hi_a_q, hi_b_d, hi_b_q;
    logic [RESW-1:0] res_d, res_q;
    logic            v1_d, v1_q, done_d, done_q;

    // Subtraction as a + ~b + 1 over RESW bits, so the top bit reads as borrow.
    assign ext_a = {1'b0, in_a};
    assign ext_b = subtract ? ~{1'b0, in_b} : {1'b0, in_b};

    always_comb begin
        lo_d   = lo_q;
        hi_a_d = hi_a_q;
        hi_b_d = hi_b_q;
        res_d  = res_q;
        v1_d   = start;
        done_d = v1_q;
        if (start) begin
            lo_d   = {1'b0, ext_a[LOW-1:0]} + {1'b0, ext_b[LOW-1:0]} + {{LOW{1'b0}}, subtract};
            hi_a_d = ext_a[RESW-1:LOW];
            hi_b_d = ext_b[RESW-1:LOW];
        end
        if (v1_q) begin
            res_d = {hi_a_q + hi_b_q + {{(HIW-1){1'b0}}, lo_q[LOW]}, lo_q[LOW-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lo_q   <= '0;
            hi_a_q <= '0;
            hi_b_q <= '0;
            res_q  <= '0;
            v1_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            hi_a_q <= hi_a_d;
            hi_b_q <= hi_b_d;
            res_q  <= res_d;
            v1_q   <= v1_d;
            done_q <= done_d;
        end
    end

    assign result = res_q;
    assign done   = done_q;
endmodule

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract: one raw add/sub pass, then one correction pass on the same adder.
module mod_addsub_ctrl import rsa_pkg::*; #(
    parameter int OPW = rsa_pkg::OPW
) (
    input  logic           clk,
    input  logic           resetn,
    mod_addsub_ctrl_if.slave bus
);
    state_t          state_d, state_q;
    logic [ADDW-1:0] a_d, a_q, b_d, b_q, m_d, m_q, s_d, s_q;
    logic            sub_d, sub_q, f_d, f_q;
    logic [OPW-1:0]  result_d, result_q;
    logic            done_d, done_q;

    logic            phase2;
    logic            add_start, add_sub, add_done;
    logic [ADDW-1:0] add_a, add_b, final_val;
    logic [RESW-1:0] add_res;

    // Correction pass: add -> S-M, keep it unless it borrowed; sub -> S+M, keep it only if A<B.
    assign phase2    = (state_q == OP2) || (state_q == WAIT2);
    assign add_start = (state_q == OP1) || (state_q == OP2);
    assign add_a     = phase2 ? s_q : a_q;
    assign add_b     = phase2 ? m_q : b_q;
    assign add_sub   = phase2 ? ~sub_q : sub_q;

    always_comb begin
        final_val = s_q;
        if (sub_q ? f_q : !add_res[RESW-1]) begin
            final_val = add_res[ADDW-1:0];
        end
    end

    mpadder u_adder (
        .clk      (clk),
        .resetn   (resetn),
        .start    (add_start),
        .subtract (add_sub),
        .in_a     (add_a),
        .in_b     (add_b),
        .result   (add_res),
        .done     (add_done)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        s_d      = s_q;
        sub_d    = sub_q;
        f_d      = f_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = ADDW'(bus.in_a);
                    b_d     = ADDW'(bus.in_b);
                    m_d     = ADDW'(bus.in_m);
                    sub_d   = bus.subtract;
                    state_d = OP1;
                end
            end
            OP1:   state_d = WAIT1;
            WAIT1: begin
                if (add_done) begin
                    s_d     = add_res[ADDW-1:0];
                    f_d     = add_res[RESW-1];
                    state_d = OP2;
                end
            end
            OP2:   state_d = WAIT2;
            WAIT2: begin
                if (add_done) begin
                    result_d = final_val[OPW-1:0];
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            s_q      <= '0;
            sub_q    <= 1'b0;
            f_q      <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            s_q      <= s_d;
            sub_q    <= sub_d;
            f_q      <= f_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result    = result_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a queue-based scoreboard on done.
module tb_mod_addsub_ctrl;
    import rsa_pkg::*;

    localparam int W = 1024;

    logic clk;
    logic resetn;
    int   cyc;
    int   n_checks;
    int   n_errors;
    logic prev_done;

    logic [W-1:0] exp_q[$];
    int           t0_q[$];

    mod_addsub_ctrl_if #(.OPW(W)) bus ();

    mod_addsub_ctrl #(.OPW(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time expired, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        int           t0;
        if (bus.done) begin
            n_checks++;
            if (prev_done) begin
                n_errors++;
                $display("FAIL done_width: done high two cycles in a row, required one-cycle pulse");
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: done=1 with result %0h, required no done", bus.result[127:0]);
            end else begin
                exp_v = exp_q.pop_front();
                t0    = t0_q.pop_front();
                if (bus.result !== exp_v) begin
                    n_errors++;
                    $display("FAIL result: got %0h required %0h (low 128b)", bus.result[127:0], exp_v[127:0]);
                end
                n_checks++;
                if (cyc - t0 != 6) begin
                    n_errors++;
                    $display("FAIL latency: got %0d cycles required 6", cyc - t0);
                end
            end
        end
        prev_done = bus.done;
    end

    // Driver: called at a negedge; returns at the negedge after start was sampled.
    task automatic issue_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] m, input logic [W-1:0] exp_v, input bit push);
        int guard;
        guard = 0;
        while (bus.busy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (bus.busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: busy=1 after 40 cycles, required 0");
        end
        bus.subtract = sub;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_m     = m;
        bus.start    = 1'b1;
        if (push) begin
            exp_q.push_back(exp_v);
            t0_q.push_back(cyc + 1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_a  = '0;
        bus.in_b  = '0;
        bus.in_m  = '0;
    endtask

    task automatic check_val(input string name, input logic [W-1:0] got, input logic [W-1:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, got[127:0], req[127:0]);
        end
    endtask

    logic [W-1:0] big_m, big_a, big_exp;

    initial begin
        int guard;
        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        prev_done = 1'b0;
        resetn    = 1'b0;
        bus.start    = 1'b0;
        bus.subtract = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_m     = '0;
        big_m   = '1;
        big_a   = big_m - 1;
        big_exp = big_m - 2;

        repeat (3) @(negedge clk);
        check_val("reset_result", bus.result, '0);
        check_val("reset_done", W'(bus.done), '0);
        check_val("reset_busy", W'(bus.busy), '0);
        check_val("reset_state", W'(bus.dbg_state), W'(IDLE));
        resetn = 1'b1;

        // Start on the first cycle out of reset
        issue_op(1'b0, W'(7),  W'(9),  W'(13), W'(3),  1'b1);
        issue_op(1'b1, W'(5),  W'(8),  W'(13), W'(10), 1'b1);
        issue_op(1'b1, W'(8),  W'(5),  W'(13), W'(3),  1'b1);
        issue_op(1'b0, W'(6),  W'(7),  W'(13), W'(0),  1'b1);
        issue_op(1'b1, W'(12), W'(12), W'(13), W'(0),  1'b1);
        issue_op(1'b0, big_a,  big_a,  big_m,  big_exp, 1'b1);
        issue_op(1'b1, W'(0),  big_a,  big_m,  W'(1),  1'b1);
        issue_op(1'b0, W'(999), W'(999), W'(1000), W'(998), 1'b1);
        issue_op(1'b0, W'(0),  W'(0),  W'(13), W'(0),  1'b1);

        // Second start while the first operation sits in WAIT1
        issue_op(1'b0, W'(11), W'(4), W'(13), W'(2), 1'b1);
        @(negedge clk);
        check_val("wait1_state", W'(bus.dbg_state), W'(WAIT1));
        bus.subtract = 1'b1;
        bus.in_a     = W'(1);
        bus.in_b     = W'(2);
        bus.in_m     = W'(7);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // Reset pulse during WAIT2 aborts without done
        issue_op(1'b0, W'(3), W'(4), W'(13), W'(7), 1'b0);
        guard = 0;
        while (bus.dbg_state != WAIT2 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_val("reach_wait2", W'(bus.dbg_state), W'(WAIT2));
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check_val("abort_result", bus.result, '0);
        check_val("abort_done", W'(bus.done), '0);
        check_val("abort_busy", W'(bus.busy), '0);
        issue_op(1'b1, W'(2), W'(9), W'(13), W'(6), 1'b1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (10) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_ops: %0d outstanding, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
